servo_pwm_driver: RTL and testbench
===================================

// Module: servo_pwm_driver
// PURPOSE
//  Downstream of the line-follower decision logic: consumes the 2-bit servo_instruction
//  and drives two continuous-rotation servos (left, right) with 50 Hz PWM frames.
//  Pulse widths are latched once per frame and optionally slewed to avoid wheel jerk.
//  Sits between the control core and the Basys PMOD servo pins.
// PARAMETERS
//  FRAME_CYCLES  2_000_000  clocks per PWM frame (20 ms @ 100 MHz)
//  PW_STOP       150_000    pulse width (clocks) for servo stop, 1.5 ms
//  PW_DELTA      50_000     offset from PW_STOP for full speed, 0.5 ms
//  RAMP_STEP     5_000      max pulse-width change per frame (ramp builds only)
// PORTS
//  clk                input   1  system clock
//  rst                input   1  reset, synchronous, active-low
//  servo_instruction  input   2  00 stop, 01 turn left, 10 turn right, 11 forward
//  pwm_left           output  1  PWM to left servo
//  pwm_right          output  1  PWM to right servo (mirror-mounted)
//  frame_tick         output  1  one-cycle pulse marking frame start
// BEHAVIOUR
//  - One clock; reset synchronous, active-low; all state clears on a clk edge with rst==0.
//  - Reset values: cnt=0, pw_l=pw_r=PW_STOP, tgt_l=tgt_r=PW_STOP; pwm_left=pwm_right=frame_tick=0.
//  - cnt: $clog2(FRAME_CYCLES) bits, counts 0..FRAME_CYCLES-1, wraps to 0; no other wrap.
//  - Outputs registered, 1-cycle latency: pwm_x <= (cnt < pw_x); frame_tick <= (cnt==0).
//  - First cycle after reset release has cnt=0 -> pwm high from the next edge.
//  - Target map (L, R): 00 (STOP, STOP); 01 (STOP, STOP-DELTA); 10 (STOP+DELTA, STOP);
//    11 (STOP+DELTA, STOP-DELTA). Forward = L above STOP, R below STOP.
//  - servo_instruction sampled only at cnt==FRAME_CYCLES-1; values at any other cycle ignored.
//    The same edge updates pw_l/pw_r so the new width applies to the whole next frame.
//  - Mid-frame width never changes; no glitch pulses; pw_x never outside
//    [PW_STOP-PW_DELTA, PW_STOP+PW_DELTA].
//  - Input is same-domain (registered by control core); no synchronizer here.
//  - Reset mid-frame: outputs 0 on next edge, frame restarts at cnt=0 with PW_STOP; ramp state lost.
//  - Width arithmetic unsigned, width $clog2(FRAME_CYCLES)+1; PW_STOP+PW_DELTA < FRAME_CYCLES required.
// CONFIGURATION
//  SERVO_RAMP_EN defined: at each frame boundary pw_x moves toward target by RAMP_STEP;
//    if |target-pw_x| <= RAMP_STEP, pw_x = target exactly (no overshoot). Direction
//    reversal mid-ramp simply ramps back from current pw_x.
//  SERVO_RAMP_EN undefined: pw_x = target at the frame boundary (step response); RAMP_STEP unused.
// TESTING (sim params: FRAME_CYCLES=100, PW_STOP=15, PW_DELTA=5, RAMP_STEP=2)
//  1 rst=0 for 5 cycles, instr=00 -> pwm_*=0, frame_tick=0; after release frame_tick every 100 cycles, both pwm high 15/100.
//  2 no ramp, instr=11 from reset -> frame 1 L=15,R=15; frame 2 onward L high 20, R high 10.
//  3 SERVO_RAMP_EN, 00->11 -> L widths 15,17,19,20,20; R widths 15,13,11,10,10.
//  4 instr 11->01 at cnt=50, back to 11 at cnt=60 -> no width change in this or next frame.
//  5 instr=10 steady, rst=0 one cycle at cnt=40 -> pwm_*=0 next edge, restart cnt=0, frame widths 15 then L=20,R=15.
//  6 no ramp, alternate 01/10 each frame -> widths track one frame late: (15,10),(20,15),(15,10).

Source files
------------

// File: rtl/servo_pwm_driver.sv
// Dual continuous-rotation servo PWM driver: 50 Hz frames, widths latched per frame.
// Define SERVO_RAMP_EN to slew widths by RAMP_STEP per frame instead of stepping.
module servo_pwm_driver #(
  parameter int unsigned FRAME_CYCLES = 2_000_000,
  parameter int unsigned PW_STOP      = 150_000,
  parameter int unsigned PW_DELTA     = 50_000,
  parameter int unsigned RAMP_STEP    = 5_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] servo_instruction,
  output logic       pwm_left,
  output logic       pwm_right,
  output logic       frame_tick
);

  localparam int unsigned CW = $clog2(FRAME_CYCLES);
  localparam int unsigned WW = CW + 1;

`ifdef SERVO_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  // Without ramping the step covers the full width range, so the target is always reached.
  localparam int unsigned STEP = RAMP_EN ? RAMP_STEP : (2 * PW_DELTA);

  localparam logic [WW-1:0] W_STOP = WW'(PW_STOP);
  localparam logic [WW-1:0] W_FWD  = WW'(PW_STOP + PW_DELTA);
  localparam logic [WW-1:0] W_REV  = WW'(PW_STOP - PW_DELTA);
  localparam logic [WW-1:0] W_STEP = WW'(STEP);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] pw_l_q, pw_l_d, pw_r_q, pw_r_d;
  logic [WW-1:0] tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
  logic [WW-1:0] map_l_c, map_r_c;
  logic          boundary_c;

  // Move cur toward tgt by at most W_STEP, landing exactly on tgt when close enough.
  function automatic logic [WW-1:0] slew(input logic [WW-1:0] cur, input logic [WW-1:0] tgt);
    logic [WW-1:0] diff;
    if (tgt >= cur) begin
      diff = tgt - cur;
      slew = (diff <= W_STEP) ? tgt : (cur + W_STEP);
    end else begin
      diff = cur - tgt;
      slew = (diff <= W_STEP) ? tgt : (cur - W_STEP);
    end
  endfunction

  // Instruction to per-wheel target; the right servo is mirror-mounted.
  always_comb begin
    map_l_c = W_STOP;
    map_r_c = W_STOP;
    case (servo_instruction)
      2'b01: map_r_c = W_REV;
      2'b10: map_l_c = W_FWD;
      2'b11: begin
        map_l_c = W_FWD;
        map_r_c = W_REV;
      end
      default: ;
    endcase
  end

  assign boundary_c = (cnt_q == CW'(FRAME_CYCLES - 1));

  // Frame counter and per-frame width latch.
  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    tgt_l_d = tgt_l_q;
    tgt_r_d = tgt_r_q;
    pw_l_d  = pw_l_q;
    pw_r_d  = pw_r_q;
    if (boundary_c) begin
      cnt_d   = '0;
      tgt_l_d = map_l_c;
      tgt_r_d = map_r_c;
      pw_l_d  = slew(pw_l_q, map_l_c);
      pw_r_d  = slew(pw_r_q, map_r_c);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      pw_l_q     <= W_STOP;
      pw_r_q     <= W_STOP;
      tgt_l_q    <= W_STOP;
      tgt_r_q    <= W_STOP;
      pwm_left   <= 1'b0;
      pwm_right  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pw_l_q     <= pw_l_d;
      pw_r_q     <= pw_r_d;
      tgt_l_q    <= tgt_l_d;
      tgt_r_q    <= tgt_r_d;
      pwm_left   <= ({1'b0, cnt_q} < pw_l_q);
      pwm_right  <= ({1'b0, cnt_q} < pw_r_q);
      frame_tick <= (cnt_q == '0);
    end
  end

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Self-checking bench for servo_pwm_driver: per-frame width scoreboard plus reset sequences.
module tb_servo_pwm_driver;

  localparam int unsigned FC    = 100;
  localparam int unsigned STOP  = 15;
  localparam int unsigned DELTA = 5;
  localparam int unsigned RSTEP = 2;

`ifdef SERVO_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] instr;
  logic       pwm_left;
  logic       pwm_right;
  logic       frame_tick;

  servo_pwm_driver #(
    .FRAME_CYCLES(FC),
    .PW_STOP     (STOP),
    .PW_DELTA    (DELTA),
    .RAMP_STEP   (RSTEP)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .servo_instruction(instr),
    .pwm_left         (pwm_left),
    .pwm_right        (pwm_right),
    .frame_tick       (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int l;
    int r;
  } exp_t;

  typedef struct {
    logic [1:0] instr;
    bit         glitch;
    logic [1:0] ginstr;
    bit         rst_mid;
    int         el;
    int         er;
  } vec_t;

  localparam int NV = 16;

  exp_t sb[$];
  vec_t vt[NV];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   in_frame = 1'b0;
  int   cyc, hl, hr;
  bit   gl, gr;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [1:0] ins, input bit g, input logic [1:0] gi,
                         input bit rm, input int sl, input int sr, input int rl, input int rr);
    vt[i].instr   = ins;
    vt[i].glitch  = g;
    vt[i].ginstr  = gi;
    vt[i].rst_mid = rm;
    vt[i].el      = RAMP ? rl : sl;
    vt[i].er      = RAMP ? rr : sr;
  endtask

  task automatic finish_frame();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_underflow got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check("period", cyc, int'(FC));
      check("width_l", hl, e.l);
      check("width_r", hr, e.r);
      check("glitch_l", int'(gl), 0);
      check("glitch_r", int'(gr), 0);
    end
  endtask

  // Measure each frame between frame_tick samples; high time must be one run from frame start.
  always @(negedge clk) begin
    if (!mon_en) begin
      in_frame = 1'b0;
    end else begin
      if (frame_tick === 1'b1) begin
        if (in_frame) finish_frame();
        in_frame = 1'b1;
        cyc = 0;
        hl  = 0;
        hr  = 0;
        gl  = 1'b0;
        gr  = 1'b0;
      end
      if (in_frame) begin
        if (pwm_left === 1'b1) begin
          if (hl != cyc) gl = 1'b1;
          hl++;
        end
        if (pwm_right === 1'b1) begin
          if (hr != cyc) gr = 1'b1;
          hr++;
        end
        cyc++;
      end
    end
  end

  // Drive the instruction for one frame boundary and queue the width of the frame after it.
  task automatic run_frame(input vec_t v);
    exp_t e;
    instr = v.instr;
    e.l = v.el;
    e.r = v.er;
    sb.push_back(e);
    if (v.glitch) begin
      edges(50);
      instr = v.ginstr;
      edges(10);
      instr = v.instr;
      edges(40);
    end else begin
      edges(int'(FC));
    end
  endtask

  task automatic check_outputs_low(input string tag);
    check({tag, "_pwm_l"}, (pwm_left === 1'b0) ? 0 : 1, 0);
    check({tag, "_pwm_r"}, (pwm_right === 1'b0) ? 0 : 1, 0);
    check({tag, "_tick"}, (frame_tick === 1'b0) ? 0 : 1, 0);
  endtask

  task automatic release_reset();
    exp_t e;
    rst = 1'b1;
    sb.delete();
    e.l = int'(STOP);
    e.r = int'(STOP);
    sb.push_back(e);
    mon_en = 1'b1;
  endtask

  initial begin
    //          idx instr glt ginstr rst  step(L,R)  ramp(L,R)
    set_vec(0,  2'b11, 0, 2'b00, 0,  20, 10,  17, 13);
    set_vec(1,  2'b11, 0, 2'b00, 0,  20, 10,  19, 11);
    set_vec(2,  2'b11, 0, 2'b00, 0,  20, 10,  20, 10);
    set_vec(3,  2'b11, 0, 2'b00, 0,  20, 10,  20, 10);
    set_vec(4,  2'b11, 1, 2'b01, 0,  20, 10,  20, 10);
    set_vec(5,  2'b01, 0, 2'b00, 0,  15, 10,  18, 10);
    set_vec(6,  2'b10, 0, 2'b00, 0,  20, 15,  20, 12);
    set_vec(7,  2'b01, 0, 2'b00, 0,  15, 10,  18, 10);
    set_vec(8,  2'b10, 0, 2'b00, 0,  20, 15,  20, 12);
    set_vec(9,  2'b00, 0, 2'b00, 0,  15, 15,  18, 14);
    set_vec(10, 2'b00, 1, 2'b11, 0,  15, 15,  16, 15);
    set_vec(11, 2'b10, 0, 2'b00, 0,  20, 15,  18, 15);
    set_vec(12, 2'b00, 0, 2'b00, 0,  15, 15,  16, 15);
    set_vec(13, 2'b10, 0, 2'b00, 1,  20, 15,  17, 15);
    set_vec(14, 2'b10, 0, 2'b00, 0,  20, 15,  19, 15);
    set_vec(15, 2'b10, 0, 2'b00, 0,  20, 15,  20, 15);

    rst    = 1'b0;
    instr  = 2'b00;
    mon_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      edges(1);
      check_outputs_low("reset");
    end
    release_reset();

    for (int i = 0; i < NV; i++) begin
      if (vt[i].rst_mid) begin
        // Reset pulse at cnt==40 of a frame already in flight.
        instr = vt[i].instr;
        edges(40);
        rst    = 1'b0;
        mon_en = 1'b0;
        edges(1);
        check_outputs_low("midrst");
        release_reset();
      end
      run_frame(vt[i]);
    end

    edges(int'(FC) + 2);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
